// File: rtl/branch_predict_unit.sv
// Branch prediction and resolution unit: bimodal or gshare table of
// saturating counters, ID-stage predict/target/flush, EX-stage resolve/train.
//
// Ports:
//   clk_i, rst_i              clock (rising edge), async active-low reset
//   id_branch_i/pc/imm        ID-stage branch lookup inputs
//   id_taken_o/target/index   prediction, taken target, table index used
//   id_flush_o                flush IF/ID and load id_target_o into PC
//   ex_branch_i/pc/target/    EX-stage resolution inputs carried from ID
//   ex_index_i/pred/taken
//   ex_mispredict_o           prediction wrong; flush IF/ID and ID/EX
//   ex_redirect_pc_o          correct next PC on mispredict, else 0
//   branch_count_o            resolved branches since reset
//   mispredict_count_o        mispredicts since reset
module branch_predict_unit #(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 4,
    parameter int CTR_BITS   = 2,
    parameter int HIST_BITS  = 0,
    parameter int CNT_BITS   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  id_branch_i,
    input  logic [XLEN-1:0]       id_pc_i,
    input  logic [XLEN-1:0]       id_imm_i,
    output logic                  id_taken_o,
    output logic [XLEN-1:0]       id_target_o,
    output logic [INDEX_BITS-1:0] id_index_o,
    output logic                  id_flush_o,

    input  logic                  ex_branch_i,
    input  logic [XLEN-1:0]       ex_pc_i,
    input  logic [XLEN-1:0]       ex_target_i,
    input  logic [INDEX_BITS-1:0] ex_index_i,
    input  logic                  ex_pred_i,
    input  logic                  ex_taken_i,
    output logic                  ex_mispredict_o,
    output logic [XLEN-1:0]       ex_redirect_pc_o,

    output logic [CNT_BITS-1:0]   branch_count_o,
    output logic [CNT_BITS-1:0]   mispredict_count_o
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    localparam logic [CTR_BITS-1:0] CTR_WEAK =
        CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_MIN = '0;

    // ------------------------------------------------------------
    // Counter table (flip-flops)
    // ------------------------------------------------------------
    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_old;
    logic [CTR_BITS-1:0] ctr_new;

    // ------------------------------------------------------------
    // Index: PC word bits, optionally hashed with global history
    // ------------------------------------------------------------
    logic [INDEX_BITS-1:0] base_idx;
    logic [INDEX_BITS-1:0] hist_idx;

    assign base_idx = id_pc_i[INDEX_BITS+1:2];

    generate
        if (HIST_BITS > 0) begin : g_gshare
            logic [HIST_BITS-1:0] ghr_q;

            assign hist_idx = INDEX_BITS'(ghr_q);

            // History is non-speculative: only resolved outcomes enter it.
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    ghr_q <= '0;
                end else if (ex_branch_i) begin
                    if (HIST_BITS == 1) begin
                        ghr_q <= HIST_BITS'(ex_taken_i);
                    end else begin
                        ghr_q <= HIST_BITS'({ghr_q, ex_taken_i});
                    end
                end
            end
        end else begin : g_bimodal
            assign hist_idx = '0;
        end
    endgenerate

    assign id_index_o = base_idx ^ hist_idx;

    // ------------------------------------------------------------
    // ID stage: prediction, target, flush
    // ------------------------------------------------------------
    // Lookup reads the registered table, so a same-cycle EX update
    // of the same entry is seen only from the next cycle on.
    assign id_taken_o  = ctr_q[id_index_o][CTR_BITS-1];
    assign id_target_o = id_pc_i + (id_imm_i << 1);

    // A mispredict in EX means the ID instruction is wrong-path.
    assign id_flush_o = id_branch_i & id_taken_o & ~ex_mispredict_o;

    // ------------------------------------------------------------
    // EX stage: resolution
    // ------------------------------------------------------------
    assign ex_mispredict_o = ex_branch_i & (ex_pred_i != ex_taken_i);

    always_comb begin
        ex_redirect_pc_o = '0;
        if (ex_mispredict_o) begin
            ex_redirect_pc_o = ex_taken_i ? ex_target_i
                                          : ex_pc_i + XLEN'(4);
        end
    end

    // ------------------------------------------------------------
    // Training: saturating update of the resolved entry
    // ------------------------------------------------------------
    assign ctr_old = ctr_q[ex_index_i];

    always_comb begin
        ctr_new = ctr_old;
        if (ex_taken_i) begin
            if (ctr_old != CTR_MAX) begin
                ctr_new = ctr_old + CTR_BITS'(1);
            end
        end else begin
            if (ctr_old != CTR_MIN) begin
                ctr_new = ctr_old - CTR_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WEAK;
            end
        end else if (ex_branch_i) begin
            ctr_q[ex_index_i] <= ctr_new;
        end
    end

    // ------------------------------------------------------------
    // Performance counters (wrapping)
    // ------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            branch_count_o     <= '0;
            mispredict_count_o <= '0;
        end else if (ex_branch_i) begin
            branch_count_o     <= branch_count_o + CNT_BITS'(1);
            mispredict_count_o <= mispredict_count_o
                                + CNT_BITS'(ex_mispredict_o);
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: table-driven vectors on a
// bimodal instance plus hand sequences for async reset and gshare history.
module tb_branch_predict_unit;

    logic        clk;
    logic        rst;
    logic        id_branch;
    logic [31:0] id_pc;
    logic [31:0] id_imm;
    logic        ex_branch;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic [3:0]  ex_index;
    logic        ex_pred;
    logic        ex_taken;

    logic        a_taken, b_taken;
    logic [31:0] a_target, b_target;
    logic [3:0]  a_index, b_index;
    logic        a_flush, b_flush;
    logic        a_mis, b_mis;
    logic [31:0] a_redir, b_redir;
    logic [31:0] a_bc, b_bc;
    logic [31:0] a_mc, b_mc;

    int checks;
    int passes;

    branch_predict_unit #(.HIST_BITS(0)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .id_branch_i(id_branch), .id_pc_i(id_pc), .id_imm_i(id_imm),
        .id_taken_o(a_taken), .id_target_o(a_target),
        .id_index_o(a_index), .id_flush_o(a_flush),
        .ex_branch_i(ex_branch), .ex_pc_i(ex_pc),
        .ex_target_i(ex_target), .ex_index_i(ex_index),
        .ex_pred_i(ex_pred), .ex_taken_i(ex_taken),
        .ex_mispredict_o(a_mis), .ex_redirect_pc_o(a_redir),
        .branch_count_o(a_bc), .mispredict_count_o(a_mc)
    );

    branch_predict_unit #(.HIST_BITS(2)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .id_branch_i(id_branch), .id_pc_i(id_pc), .id_imm_i(id_imm),
        .id_taken_o(b_taken), .id_target_o(b_target),
        .id_index_o(b_index), .id_flush_o(b_flush),
        .ex_branch_i(ex_branch), .ex_pc_i(ex_pc),
        .ex_target_i(ex_target), .ex_index_i(ex_index),
        .ex_pred_i(ex_pred), .ex_taken_i(ex_taken),
        .ex_mispredict_o(b_mis), .ex_redirect_pc_o(b_redir),
        .branch_count_o(b_bc), .mispredict_count_o(b_mc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        idb;
        logic [31:0] idpc;
        logic [31:0] idimm;
        logic        exb;
        logic [31:0] expc;
        logic [31:0] extgt;
        logic [3:0]  exidx;
        logic        expred;
        logic        extaken;
        logic        e_taken;
        logic [31:0] e_target;
        logic [3:0]  e_index;
        logic        e_flush;
        logic        e_mis;
        logic [31:0] e_redir;
        logic [31:0] e_bc;
        logic [31:0] e_mc;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic idb, input logic [31:0] idpc, input logic [31:0] idimm,
        input logic exb, input logic [31:0] expc, input logic [31:0] extgt,
        input logic [3:0] exidx, input logic expred, input logic extaken,
        input logic e_taken, input logic [31:0] e_target,
        input logic [3:0] e_index, input logic e_flush, input logic e_mis,
        input logic [31:0] e_redir, input logic [31:0] e_bc,
        input logic [31:0] e_mc);
        vec_t v;
        v.idb = idb; v.idpc = idpc; v.idimm = idimm;
        v.exb = exb; v.expc = expc; v.extgt = extgt; v.exidx = exidx;
        v.expred = expred; v.extaken = extaken;
        v.e_taken = e_taken; v.e_target = e_target; v.e_index = e_index;
        v.e_flush = e_flush; v.e_mis = e_mis; v.e_redir = e_redir;
        v.e_bc = e_bc; v.e_mc = e_mc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b0;
        id_branch = 0; id_pc = 0; id_imm = 0;
        ex_branch = 0; ex_pc = 0; ex_target = 0; ex_index = 0;
        ex_pred = 0; ex_taken = 0;

        // idb pc imm | exb expc extgt idx pred tkn |
        // taken target index flush mis redir bc mc
        vecs[0]  = mk(1, 32'h40, 32'h8, 0, 0, 0, 0, 0, 0,
                      1, 32'h50, 0, 1, 0, 0, 0, 0);
        vecs[1]  = mk(1, 32'h40, 32'h8, 1, 32'h100, 32'h200, 0, 1, 0,
                      1, 32'h50, 0, 0, 1, 32'h104, 0, 0);
        vecs[2]  = mk(1, 32'h40, 32'h8, 1, 32'h100, 32'h200, 0, 0, 0,
                      0, 32'h50, 0, 0, 0, 0, 1, 1);
        vecs[3]  = mk(1, 32'h40, 32'h8, 1, 32'h100, 32'h200, 0, 0, 0,
                      0, 32'h50, 0, 0, 0, 0, 2, 1);
        vecs[4]  = mk(1, 32'h40, 32'h8, 0, 0, 0, 0, 0, 0,
                      0, 32'h50, 0, 0, 0, 0, 3, 1);
        vecs[5]  = mk(1, 32'h4C, 32'hFFFF_FFFE, 1, 32'h4C, 32'h48, 3, 1, 1,
                      1, 32'h48, 3, 1, 0, 0, 3, 1);
        vecs[6]  = mk(1, 32'h4C, 32'hFFFF_FFFE, 1, 32'h4C, 32'h48, 3, 1, 1,
                      1, 32'h48, 3, 1, 0, 0, 4, 1);
        vecs[7]  = mk(1, 32'h4C, 32'hFFFF_FFFE, 1, 32'h4C, 32'h48, 3, 1, 1,
                      1, 32'h48, 3, 1, 0, 0, 5, 1);
        vecs[8]  = mk(1, 32'h4C, 32'hFFFF_FFFE, 1, 32'h4C, 32'h48, 3, 1, 1,
                      1, 32'h48, 3, 1, 0, 0, 6, 1);
        vecs[9]  = mk(1, 32'h4C, 32'hFFFF_FFFE, 1, 32'h4C, 32'h48, 3, 1, 0,
                      1, 32'h48, 3, 0, 1, 32'h50, 7, 1);
        vecs[10] = mk(1, 32'h4C, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0,
                      1, 32'h48, 3, 1, 0, 0, 8, 2);
        vecs[11] = mk(0, 32'hFFFF_FFFC, 32'h4, 0, 32'h10, 32'h20, 0, 1, 0,
                      1, 32'h4, 4'hF, 0, 0, 0, 8, 2);
        vecs[12] = mk(1, 32'h40, 32'h8, 1, 32'h80, 32'h1000, 5, 0, 1,
                      0, 32'h50, 0, 0, 1, 32'h1000, 8, 2);
        vecs[13] = mk(1, 32'h54, 32'h0, 0, 0, 0, 0, 0, 0,
                      1, 32'h54, 5, 1, 0, 0, 9, 3);

        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            id_branch = vecs[i].idb;
            id_pc     = vecs[i].idpc;
            id_imm    = vecs[i].idimm;
            ex_branch = vecs[i].exb;
            ex_pc     = vecs[i].expc;
            ex_target = vecs[i].extgt;
            ex_index  = vecs[i].exidx;
            ex_pred   = vecs[i].expred;
            ex_taken  = vecs[i].extaken;
            #1;
            check($sformatf("v%0d taken", i), 32'(a_taken),
                  32'(vecs[i].e_taken));
            check($sformatf("v%0d target", i), a_target, vecs[i].e_target);
            check($sformatf("v%0d index", i), 32'(a_index),
                  32'(vecs[i].e_index));
            check($sformatf("v%0d flush", i), 32'(a_flush),
                  32'(vecs[i].e_flush));
            check($sformatf("v%0d mispredict", i), 32'(a_mis),
                  32'(vecs[i].e_mis));
            check($sformatf("v%0d redirect", i), a_redir, vecs[i].e_redir);
            check($sformatf("v%0d branch_cnt", i), a_bc, vecs[i].e_bc);
            check($sformatf("v%0d mispred_cnt", i), a_mc, vecs[i].e_mc);
        end

        // Async reset mid-cycle: entry 0 was trained to 0, must read 2 again.
        @(negedge clk);
        ex_branch = 0;
        id_branch = 1; id_pc = 32'h40; id_imm = 32'h8;
        #1;
        check("pre-reset taken idx0", 32'(a_taken), 32'h0);
        #1;
        rst = 1'b0;
        #1;
        check("async rst taken idx0", 32'(a_taken), 32'h1);
        check("async rst flush", 32'(a_flush), 32'h1);
        check("async rst branch_cnt", a_bc, 32'h0);
        check("async rst mispred_cnt", a_mc, 32'h0);
        check("async rst gshare bc", b_bc, 32'h0);
        check("async rst gshare index", 32'(b_index), 32'h0);

        // Gshare: two taken resolutions drive history to 2'b11.
        @(negedge clk);
        rst = 1'b1;
        ex_branch = 1; ex_index = 4'h7; ex_pred = 1; ex_taken = 1;
        ex_pc = 32'h200; ex_target = 32'h300;
        #1;
        check("gshare idx ghr=00", 32'(b_index), 32'h0);
        check("bimodal idx no ghr", 32'(a_index), 32'h0);
        @(negedge clk);
        #1;
        check("gshare idx ghr=01", 32'(b_index), 32'h1);
        @(negedge clk);
        ex_branch = 0;
        #1;
        check("gshare idx ghr=11", 32'(b_index), 32'h3);
        check("gshare taken idx3", 32'(b_taken), 32'h1);
        check("bimodal idx after hist", 32'(a_index), 32'h0);
        check("gshare branch_cnt", b_bc, 32'h2);
        check("gshare mispred_cnt", b_mc, 32'h0);

        // No-branch cycles leave history and counts unchanged.
        @(negedge clk);
        ex_pred = 0;
        #1;
        check("gshare idx hold", 32'(b_index), 32'h3);
        check("gshare bc hold", b_bc, 32'h2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
